// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - Shared UART register offsets, bit indices, FSM state types and timing constants.
package uart_pkg;

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_DIV    = 4'hC;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_OVERRUN    = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_PARITY_ERR = 6;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_TXE_IE = 2;
  localparam int CTRL_RXA_IE = 3;
  localparam int CTRL_ODD    = 4;

  localparam int OVERSAMPLE = 16;
  localparam int MID_BIT    = 8;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - Synchronous FIFO with count-based full/empty and read-data at the head.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_core.sv
// rtl/apb_uart_core.sv - APB UART core: register file, baud generator, TX/RX FSMs and IRQ.
// Define UART_PARITY_EN to add a parity bit to every frame.
module apb_uart_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              Presetn,
  input  logic [ADDR_W-1:0] Paddr,
  input  logic              Psel,
  input  logic              Penable,
  input  logic              Pwrite,
  input  logic [31:0]       Pwdata,
  output logic [31:0]       Prdata,
  output logic              Pready,
  output logic              Pslverr,
  output logic              IRQ,
  output logic              TXD,
  input  logic              RXD,
  output logic              baud_o
);

`ifdef UART_PARITY_EN
  localparam logic [4:0] CTRL_WMASK = 5'h1F;
`else
  localparam logic [4:0] CTRL_WMASK = 5'h0F;
`endif
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [3:0] TICK_END = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID = 4'(MID_BIT - 1);

  logic [4:0]           r_ctrl;
  logic [15:0]          r_div;
  logic [15:0]          r_baud_cnt;
  logic                 r_baud;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 r_irq;

  tx_state_t            r_tx_state;
  logic [3:0]           r_tx_tick;
  logic [2:0]           r_tx_bit;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_txd;

  rx_state_t            r_rx_state;
  logic [3:0]           r_rx_tick;
  logic [2:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rxd_s1;
  logic                 r_rxd_s2;

  logic                 w_access, w_wr, w_rd, w_status_rd;
  logic [3:0]           w_off;
  logic [6:0]           w_status;
  logic                 w_tx_full, w_tx_empty, w_tx_push, w_tx_pop;
  logic                 w_rx_full, w_rx_empty, w_rx_push, w_rx_pop;
  logic [DATA_BITS-1:0] w_tx_data, w_rx_data;
  logic                 w_tx_bit_end, w_rx_bit_end, w_rx_mid, w_rx_stop_end;
  logic                 w_ovr_evt, w_frame_evt, w_par_evt;
  logic                 w_unused_bits;

  assign w_access    = Psel & Penable;
  assign w_wr        = w_access & Pwrite;
  assign w_rd        = w_access & ~Pwrite;
  assign w_off       = {Paddr[3:2], 2'b00};
  assign w_status_rd = w_rd & (w_off == OFF_STATUS);

  assign w_tx_push = w_wr & (w_off == OFF_DATA) & ~w_tx_full;
  assign w_rx_pop  = w_rd & (w_off == OFF_DATA) & ~w_rx_empty;
  assign w_tx_pop  = r_baud & (r_tx_state == TX_IDLE) & r_ctrl[CTRL_TX_EN] & ~w_tx_empty;

  always_comb begin
    w_status                = '0;
    w_status[ST_TX_FULL]    = w_tx_full;
    w_status[ST_TX_EMPTY]   = w_tx_empty;
    w_status[ST_RX_FULL]    = w_rx_full;
    w_status[ST_RX_EMPTY]   = w_rx_empty;
    w_status[ST_OVERRUN]    = r_overrun;
    w_status[ST_FRAME_ERR]  = r_frame_err;
    w_status[ST_PARITY_ERR] = r_parity_err;
  end

  always_comb begin
    Prdata = 32'd0;
    if (w_rd) begin
      case (w_off)
        OFF_DATA:   if (!w_rx_empty) Prdata = 32'(w_rx_data);
        OFF_STATUS: Prdata = 32'(w_status);
        OFF_CTRL:   Prdata = 32'(r_ctrl);
        OFF_DIV:    Prdata = 32'(r_div);
        default:    Prdata = 32'd0;
      endcase
    end
  end

  assign Pslverr = w_wr & (((w_off == OFF_DATA) & w_tx_full) | (w_off == OFF_STATUS));
  assign Pready  = 1'b1;
  assign IRQ     = r_irq;
  assign TXD     = r_txd;
  assign baud_o  = r_baud;

  always_ff @(posedge clk) begin
    if (!Presetn) begin
      r_ctrl <= '0;
      r_div  <= '0;
    end else if (w_wr) begin
      if (w_off == OFF_CTRL) r_ctrl <= Pwdata[4:0] & CTRL_WMASK;
      if (w_off == OFF_DIV)  r_div  <= Pwdata[15:0];
    end
  end

  // A DIV write restarts the period so the new rate applies immediately.
  always_ff @(posedge clk) begin
    if (!Presetn) begin
      r_baud_cnt <= '0;
      r_baud     <= 1'b0;
    end else if (w_wr && (w_off == OFF_DIV)) begin
      r_baud_cnt <= '0;
      r_baud     <= 1'b0;
    end else if (r_baud_cnt == r_div) begin
      r_baud_cnt <= '0;
      r_baud     <= 1'b1;
    end else begin
      r_baud_cnt <= r_baud_cnt + 16'd1;
      r_baud     <= 1'b0;
    end
  end

  assign w_tx_bit_end = (r_tx_tick == TICK_END);

  always_ff @(posedge clk) begin
    if (!Presetn) begin
      r_tx_state <= TX_IDLE;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
    end else if (r_baud) begin
      r_tx_tick <= r_tx_tick + 4'd1;
      case (r_tx_state)
        TX_IDLE: begin
          r_tx_tick <= '0;
          if (w_tx_pop) begin
            r_tx_state <= TX_START;
            r_tx_shift <= w_tx_data;
            r_tx_par   <= (^w_tx_data) ^ r_ctrl[CTRL_ODD];
            r_txd      <= 1'b0;
          end
        end
        TX_START: if (w_tx_bit_end) begin
          r_tx_state <= TX_DATA;
          r_tx_bit   <= '0;
          r_txd      <= r_tx_shift[0];
        end
        TX_DATA: if (w_tx_bit_end) begin
          if (r_tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
            r_tx_state <= TX_PARITY;
            r_txd      <= r_tx_par;
`else
            r_tx_state <= TX_STOP;
            r_txd      <= 1'b1;
`endif
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= r_tx_shift >> 1;
            r_txd      <= r_tx_shift[1];
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: if (w_tx_bit_end) begin
          r_tx_state <= TX_STOP;
          r_txd      <= 1'b1;
        end
`endif
        TX_STOP: if (w_tx_bit_end) begin
          r_tx_state <= TX_IDLE;
        end
        default: begin
          r_tx_state <= TX_IDLE;
          r_txd      <= 1'b1;
        end
      endcase
    end
  end

  assign w_rx_bit_end  = (r_rx_tick == TICK_END);
  assign w_rx_mid      = (r_rx_tick == TICK_MID);
  assign w_rx_stop_end = r_baud & (r_rx_state == RX_STOP) & w_rx_bit_end;
  assign w_rx_push     = w_rx_stop_end & r_rxd_s2 & ~w_rx_full;
  assign w_ovr_evt     = w_rx_stop_end & r_rxd_s2 & w_rx_full;
  assign w_frame_evt   = w_rx_stop_end & ~r_rxd_s2;
`ifdef UART_PARITY_EN
  assign w_par_evt     = r_baud & (r_rx_state == RX_PARITY) & w_rx_bit_end &
                         (r_rxd_s2 != ((^r_rx_shift) ^ r_ctrl[CTRL_ODD]));
  assign w_unused_bits = ^{Paddr[ADDR_W-1:4], Paddr[1:0], Pwdata[31:16]};
`else
  assign w_par_evt     = 1'b0;
  assign w_unused_bits = ^{Paddr[ADDR_W-1:4], Paddr[1:0], Pwdata[31:16], r_tx_par};
`endif

  always_ff @(posedge clk) begin
    if (!Presetn) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rxd_s1 <= RXD;
      r_rxd_s2 <= r_rxd_s1;
      if (r_baud) begin
        r_rx_tick <= r_rx_tick + 4'd1;
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_tick <= '0;
            if (r_ctrl[CTRL_RX_EN] && !r_rxd_s2) r_rx_state <= RX_START;
          end
          // Half a bit later the line must still be low, otherwise it was a glitch.
          RX_START: if (w_rx_mid) begin
            r_rx_tick  <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_DATA;
          end
          RX_DATA: if (w_rx_bit_end) begin
            r_rx_shift <= {r_rxd_s2, r_rx_shift[DATA_BITS-1:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_rx_state <= RX_PARITY;
`else
              r_rx_state <= RX_STOP;
`endif
            end
          end
`ifdef UART_PARITY_EN
          RX_PARITY: if (w_rx_bit_end) r_rx_state <= RX_STOP;
`endif
          RX_STOP: if (w_rx_bit_end) r_rx_state <= RX_IDLE;
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  // STATUS reads clear the sticky bits; an event on the same edge wins.
  always_ff @(posedge clk) begin
    if (!Presetn) begin
      r_overrun    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_overrun    <= (r_overrun    & ~w_status_rd) | w_ovr_evt;
      r_frame_err  <= (r_frame_err  & ~w_status_rd) | w_frame_evt;
      r_parity_err <= (r_parity_err & ~w_status_rd) | w_par_evt;
      r_irq        <= (r_ctrl[CTRL_TXE_IE] & w_tx_empty) | (r_ctrl[CTRL_RXA_IE] & ~w_rx_empty) |
                      r_overrun | r_frame_err;
    end
  end

  uart_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clk    (clk),
    .resetn (Presetn),
    .i_push (w_tx_push),
    .i_pop  (w_tx_pop),
    .i_data (Pwdata[DATA_BITS-1:0]),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty),
    .o_data (w_tx_data)
  );

  uart_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_rx_fifo (
    .clk    (clk),
    .resetn (Presetn),
    .i_push (w_rx_push),
    .i_pop  (w_rx_pop),
    .i_data (r_rx_shift),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty),
    .o_data (w_rx_data)
  );

endmodule

// File: tb/tb_apb_uart_core.sv
// tb/tb_apb_uart_core.sv - Directed self-checking bench for apb_uart_core (default build, no parity).
module tb_apb_uart_core;

  logic        clk = 1'b0;
  logic        Presetn;
  logic [31:0] Paddr;
  logic        Psel, Penable, Pwrite;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready, Pslverr, IRQ, TXD, RXD, baud_o;
  logic        rxd_drv;
  logic        loop_en;
  int          n_total;
  int          n_bad;

  assign RXD = loop_en ? TXD : rxd_drv;

  always #5 clk = ~clk;

  apb_uart_core dut (
    .clk    (clk),
    .Presetn(Presetn),
    .Paddr  (Paddr),
    .Psel   (Psel),
    .Penable(Penable),
    .Pwrite (Pwrite),
    .Pwdata (Pwdata),
    .Prdata (Prdata),
    .Pready (Pready),
    .Pslverr(Pslverr),
    .IRQ    (IRQ),
    .TXD    (TXD),
    .RXD    (RXD),
    .baud_o (baud_o)
  );

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
    @(posedge clk); #1;
    Paddr = addr; Pwdata = data; Pwrite = 1'b1; Psel = 1'b1; Penable = 1'b0;
    @(posedge clk); #1;
    Penable = 1'b1;
    #1 err = Pslverr;
    @(posedge clk); #1;
    Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output logic err);
    @(posedge clk); #1;
    Paddr = addr; Pwrite = 1'b0; Psel = 1'b1; Penable = 1'b0;
    @(posedge clk); #1;
    Penable = 1'b1;
    #1 data = Prdata; err = Pslverr;
    @(posedge clk); #1;
    Psel = 1'b0; Penable = 1'b0;
  endtask

  task automatic apply_reset();
    Presetn = 1'b0; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 Presetn = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rxd_drv = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd_drv = b[i];
      repeat (16) @(posedge clk);
    end
    #1 rxd_drv = stop_bit;
    repeat (16) @(posedge clk);
    #1 rxd_drv = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        err;
    Presetn = 1'b0; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = '0; Pwdata = '0; rxd_drv = 1'b1; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (TXD !== 1'b1)   begin n_bad++; $display("FAIL reset_txd got=%b want=1", TXD); end
    n_total++; if (IRQ !== 1'b0)   begin n_bad++; $display("FAIL reset_irq got=%b want=0", IRQ); end
    n_total++; if (Pready !== 1'b1) begin n_bad++; $display("FAIL reset_pready got=%b want=1", Pready); end
    n_total++; if (baud_o !== 1'b0) begin n_bad++; $display("FAIL reset_baud got=%b want=0", baud_o); end
    n_total++; if (Prdata !== 32'd0) begin n_bad++; $display("FAIL reset_prdata got=%h want=0", Prdata); end
    Presetn = 1'b1;
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h0A) begin n_bad++; $display("FAIL reset_status got=%h want=0a", rd); end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    logic        err;
    int          p;
    apply_reset();
    apb_write(32'hC, 32'h5, err);
    apb_read(32'hC, rd, err);
    n_total++; if (rd !== 32'h5) begin n_bad++; $display("FAIL div_readback got=%h want=5", rd); end
    p = 0;
    while (baud_o !== 1'b1 && p < 50) begin @(posedge clk); #1; p++; end
    p = 0;
    do begin @(posedge clk); #1; p++; end while (baud_o !== 1'b1 && p < 50);
    n_total++; if (p !== 6) begin n_bad++; $display("FAIL baud_period got=%0d want=6", p); end
    apb_write(32'h8, 32'h1F, err);
    apb_read(32'h8, rd, err);
    n_total++; if (rd !== 32'h0F) begin n_bad++; $display("FAIL ctrl_readback got=%h want=0f", rd); end
    n_total++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL irq_txe got=%b want=1", IRQ); end
    apb_write(32'h4, 32'hFF, err);
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL status_write_err got=%b want=1", err); end
  endtask

  task automatic test_transmit();
    logic [31:0] rd;
    logic        err;
    logic [8:0]  exp_bits;
    int          cyc;
    int          n_low;
    apply_reset();
    exp_bits = {1'b1, 8'hA5};
    apb_write(32'hC, 32'h0, err);
    apb_write(32'h8, 32'h1, err);
    apb_write(32'h0, 32'hA5, err);
    cyc = 0;
    while (TXD !== 1'b0 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_total++; if (TXD !== 1'b0) begin n_bad++; $display("FAIL tx_start_timeout got=%b want=0", TXD); end
    n_low = 0;
    while (TXD === 1'b0 && n_low < 100) begin n_low++; @(posedge clk); #1; end
    n_total++; if (n_low !== 16) begin n_bad++; $display("FAIL tx_start_len got=%0d want=16", n_low); end
    repeat (8) @(posedge clk);
    #1;
    for (int k = 0; k < 9; k++) begin
      n_total++;
      if (TXD !== exp_bits[k]) begin
        n_bad++; $display("FAIL tx_bit%0d got=%b want=%b", k, TXD, exp_bits[k]);
      end
      repeat (16) @(posedge clk);
      #1;
    end
    repeat (20) @(posedge clk);
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h0A) begin n_bad++; $display("FAIL tx_done_status got=%h want=0a", rd); end
  endtask

  task automatic test_tx_full();
    logic [31:0] rd;
    logic        err;
    int          n_err;
    apply_reset();
    n_err = 0;
    for (int i = 0; i < 16; i++) begin
      apb_write(32'h0, 32'(i), err);
      if (err) n_err++;
    end
    n_total++; if (n_err !== 0) begin n_bad++; $display("FAIL txfull_early_err got=%0d want=0", n_err); end
    apb_write(32'h0, 32'h77, err);
    n_total++; if (err !== 1'b1) begin n_bad++; $display("FAIL txfull_last_err got=%b want=1", err); end
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h09) begin n_bad++; $display("FAIL txfull_status got=%h want=09", rd); end
  endtask

  task automatic test_loopback();
    logic [31:0] rd;
    logic        err;
    int          cyc;
    apply_reset();
    loop_en = 1'b1;
    apb_write(32'hC, 32'h3, err);
    apb_write(32'h8, 32'hB, err);
    apb_write(32'h0, 32'hA5, err);
    n_total++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL loop_irq_early got=%b want=0", IRQ); end
    cyc = 0;
    while (IRQ !== 1'b1 && cyc < 3000) begin @(posedge clk); #1; cyc++; end
    n_total++;
    if (IRQ !== 1'b1 || cyc < 580 || cyc > 660) begin
      n_bad++; $display("FAIL loop_irq_time got=%0d want=580..660 irq=%b", cyc, IRQ);
    end
    apb_read(32'h0, rd, err);
    n_total++; if (rd !== 32'hA5) begin n_bad++; $display("FAIL loop_data got=%h want=a5", rd); end
    n_total++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL loop_irq_hold got=%b want=1", IRQ); end
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL loop_irq_fall got=%b want=0", IRQ); end
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h0A) begin n_bad++; $display("FAIL loop_status got=%h want=0a", rd); end
  endtask

  task automatic test_framing();
    logic [31:0] rd;
    logic        err;
    apply_reset();
    apb_write(32'h8, 32'h2, err);
    send_frame(8'h3C, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL frame_irq got=%b want=1", IRQ); end
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h2A) begin n_bad++; $display("FAIL frame_status1 got=%h want=2a", rd); end
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h0A) begin n_bad++; $display("FAIL frame_status2 got=%h want=0a", rd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    logic        err;
    logic [7:0]  exp_q[$];
    logic [7:0]  b;
    apply_reset();
    apb_write(32'h8, 32'h2, err);
    for (int i = 0; i < 17; i++) begin
      b = 8'(i * 29 + 7);
      if (i < 16) exp_q.push_back(b);
      send_frame(b, 1'b1);
    end
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (IRQ !== 1'b1) begin n_bad++; $display("FAIL ovr_irq got=%b want=1", IRQ); end
    apb_read(32'h4, rd, err);
    n_total++; if (rd !== 32'h16) begin n_bad++; $display("FAIL ovr_status got=%h want=16", rd); end
    for (int i = 0; i < 16; i++) begin
      apb_read(32'h0, rd, err);
      n_total++;
      if (rd !== {24'd0, exp_q[i]}) begin
        n_bad++; $display("FAIL ovr_data%0d got=%h want=%h", i, rd, exp_q[i]);
      end
    end
    apb_read(32'h0, rd, err);
    n_total++; if (rd !== 32'd0 || err !== 1'b0) begin n_bad++; $display("FAIL empty_read got=%h err=%b want=0 err=0", rd, err); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_regs();
    test_transmit();
    test_tx_full();
    test_loopback();
    test_framing();
    test_overrun();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/apb_uart_core.md
# apb_uart_core

Parametrised APB-attached UART: a zero-wait APB3 slave register file with TX and RX FIFOs, a programmable 16x-oversample baud generator, and a level interrupt. It is the successor to the fixed single-byte UART the bench already drives through the APB/UART interface. It adds configurable data bits, FIFO depth, and optional parity. It connects the APB bus (`Paddr`…`Pslverr`) to the serial pins (`TXD`, `RXD`) and exports `IRQ` and `baud_o`.

## Interface
- `DATA_BITS`, default 8: serial payload width; legal range 5–8.
- `FIFO_DEPTH`, default 16: entries per TX and RX FIFO; must be a power of two, ≥2.
- `ADDR_W`, default 32: `Paddr` width; only `Paddr[3:2]` is decoded.
- `clk` in 1: sole clock.
- `Presetn` in 1: synchronous, active-low reset.
- `Paddr` in ADDR_W: APB address.
- `Psel`, `Penable`, `Pwrite` in 1: APB control.
- `Pwdata` in 32: write data.
- `Prdata` out 32: read data; reset 0.
- `Pready` out 1: tied 1 (zero wait states); reset 1.
- `Pslverr` out 1: error response; reset 0.
- `IRQ` out 1: registered level interrupt; reset 0.
- `TXD` out 1: serial out; reset 1 (idle).
- `RXD` in 1: serial in; asynchronous, passes through a 2-flop synchroniser.
- `baud_o` out 1: 16x oversample tick, one `clk` wide; reset 0.

## Operation
- **APB access:** an access occurs when `Psel & Penable`.
  - Writes take effect at that edge.
  - `Prdata` and `Pslverr` are combinational during the access phase and are 0 outside it.
- **Register map:**
  - 0x0 DATA: write pushes `Pwdata[DATA_BITS-1:0]` to the TX FIFO; read pops the RX FIFO, zero-extended.
  - 0x4 STATUS, read-only:
    - b0 tx_full
    - b1 tx_empty
    - b2 rx_full
    - b3 rx_empty
    - b4 overrun (sticky)
    - b5 frame_err (sticky)
    - b6 parity_err (sticky)
  - 0x8 CTRL, reset 0:
    - b0 tx_en
    - b1 rx_en
    - b2 txe_ie
    - b3 rxa_ie
    - b4 odd_parity
  - 0xC DIV[15:0], reset 0.
- **Access errors:**
  - Write to DATA while the TX FIFO is full: data is dropped and `Pslverr`=1.
  - Write to STATUS: ignored and `Pslverr`=1.
  - Read of DATA while the RX FIFO is empty: returns 0, `Pslverr`=0, no pop.
- **STATUS read:** clears b4–b6 at the access edge. If an error event occurs on the same edge, the new set wins.
- **Baud generator:** a counter reloads from DIV.
  - `baud_o` pulses once every DIV+1 clocks; DIV=0 gives a pulse every cycle.
  - A DIV write restarts the counter from 0.
- **TX state machine:** IDLE→START→DATA→[PARITY]→STOP→IDLE.
  - Each bit lasts 16 ticks.
  - Bits are sent LSB first.
  - The FSM leaves IDLE on a tick when tx_en=1 and the TX FIFO is non-empty; the pop happens on that edge.
  - Clearing tx_en mid-frame lets the current frame finish.
- **RX state machine:** IDLE→START→DATA→[PARITY]→STOP→IDLE.
  - A start is detected as a 0 on a tick while rx_en=1.
  - The start bit is re-checked 8 ticks later. If the line is 1, it is a glitch: return to IDLE with no error.
  - Each subsequent bit is sampled 16 ticks after the previous one.
  - Stop bit = 0: set frame_err and discard the byte.
  - RX FIFO full on completion: set overrun and discard the byte. The FIFO contents are untouched.
- **FIFO simultaneity:** a push and a pop on the same edge of a full or empty FIFO are both honoured when legal. The count is unchanged; pointers wrap modulo FIFO_DEPTH.
- **IRQ:** next-state value is (txe_ie & tx_empty) | (rxa_ie & ~rx_empty) | overrun | frame_err.

## Timing
- DATA write at edge N: the TX FIFO is non-empty from N+1. The start bit begins on the first tick at or after N+1 with tx_en=1.
- Frame length is (1 + DATA_BITS + P + 1) × 16 × (DIV+1) clocks, where P = 1 with parity and 0 without.
- The RX byte is visible in the RX FIFO 1 clock after the stop-bit sample tick. The `IRQ` update follows 1 clock later.
- Reset mid-frame:
  - Both FSMs return to IDLE.
  - FIFOs empty, counters 0, `TXD`=1.
  - All registers return to their reset values.

## Configuration
- `UART_PARITY_EN` defined:
  - A parity bit is inserted after the data bits: even parity, or odd when CTRL.b4=1.
  - RX checks the parity bit; a mismatch sets parity_err but the byte is still stored.
- `UART_PARITY_EN` undefined:
  - There is no PARITY state.
  - CTRL.b4 and STATUS.b6 read 0 and ignore writes.

## Structure
- Package `uart_pkg` holds:
  - register offsets
  - STATUS and CTRL bit indices
  - the `tx_state_t` and `rx_state_t` enums
  - the oversample constant 16 and mid-bit constant 8
- Sub-module `uart_fifo` (parameters WIDTH, DEPTH; ports push, pop, full, empty, data) is instantiated twice, once for TX and once for RX.

## Test plan
- **Reset:** hold `Presetn`=0 for 3 clocks → `TXD`=1, `IRQ`=0, `Pready`=1; STATUS reads 0x0A.
- **Transmit:** DIV=0, CTRL=0x1, write DATA=0xA5 → `TXD` shows 0, then 1,0,1,0,0,1,0,1, then 1; each bit is 16 clocks; STATUS.tx_empty returns to 1.
- **TX FIFO full:** with tx_en=0, write FIFO_DEPTH+1 words → the last write gets `Pslverr`=1; STATUS.tx_full=1.
- **Loopback:** drive `TXD`→`RXD` with CTRL=0xB and DIV=3 → read DATA returns 0xA5; `IRQ` asserts after the stop bit and falls after the pop.
- **Framing:** send a stop bit of 0 → STATUS.b5=1 and the RX FIFO stays empty; a second STATUS read returns b5=0.
- **RX overrun:** send FIFO_DEPTH+1 bytes without popping → overrun=1; reads return the first FIFO_DEPTH bytes in order.
